// File: rtl/snoop_initiator.sv
// ACE snoop initiator: issues one AC snoop per accepted request and gathers the CR/CD reply into one result.
// Optional busy watchdog is compiled in when SNOOP_INIT_TIMEOUT_EN is defined.

package snoop_pkg;
  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t READ_ONCE     = 4'b0000;
  localparam acsnoop_t READ_SHARED   = 4'b0001;
  localparam acsnoop_t READ_UNIQUE   = 4'b0111;
  localparam acsnoop_t CLEAN_INVALID = 4'b1001;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;
endpackage

package ariane_ace;
  typedef struct packed {
    logic [63:0]          addr;
    snoop_pkg::acsnoop_t  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    snoop_pkg::crresp_t cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;
endpackage

module snoop_initiator
  import snoop_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_addr_i,
  input  acsnoop_t                 req_snoop_i,
  output ariane_ace::snoop_req_t   snoop_port_o,
  input  ariane_ace::snoop_resp_t  snoop_port_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output crresp_t                  rsp_resp_o,
  output logic [127:0]             rsp_data_o,
  output logic                     busy_o,
  output logic                     timeout_o
);
  localparam int unsigned AddrW = 64;
  localparam int unsigned BeatW = 64;
  localparam int unsigned LineW = 128;

  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
    $error("snoop_initiator: TimeoutCycles must be within 2..65535");
  end

  typedef enum logic [2:0] {IDLE, SEND_AC, WAIT_CR, WAIT_CD, RESP} state_e;

  state_e            r_state;
  logic              r_req_ready;
  logic              r_ac_valid;
  logic              r_cr_ready;
  logic              r_cd_ready;
  logic              r_rsp_valid;
  logic              r_busy;
  logic              r_beat;
  logic [AddrW-1:0]  r_addr;
  acsnoop_t          r_snoop;
  crresp_t           r_resp;
  logic [LineW-1:0]  r_data;
  logic              w_supported;

  assign w_supported = (req_snoop_i == CLEAN_INVALID) || (req_snoop_i == READ_SHARED) ||
                       (req_snoop_i == READ_ONCE)     || (req_snoop_i == READ_UNIQUE);

  // Transaction FSM; every handshake output is a register updated with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_ac_valid  <= 1'b0;
      r_cr_ready  <= 1'b0;
      r_cd_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_beat      <= 1'b0;
      r_addr      <= '0;
      r_snoop     <= '0;
      r_resp      <= '0;
      r_data      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr      <= req_addr_i & ~AddrW'(4'hF);
            r_snoop     <= req_snoop_i;
            r_data      <= '0;
            r_resp      <= '0;
            r_beat      <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_supported) begin
              r_ac_valid <= 1'b1;
              r_state    <= SEND_AC;
            end else begin
              r_resp.error <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= RESP;
            end
          end
        end
        SEND_AC: begin
          if (snoop_port_i.ac_ready) begin
            r_ac_valid <= 1'b0;
            r_cr_ready <= 1'b1;
            r_state    <= WAIT_CR;
          end
        end
        WAIT_CR: begin
          if (snoop_port_i.cr_valid) begin
            r_cr_ready <= 1'b0;
            r_resp     <= snoop_port_i.cr_resp;
            if (snoop_port_i.cr_resp.data_transfer) begin
              r_cd_ready <= 1'b1;
              r_state    <= WAIT_CD;
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end
        end
        WAIT_CD: begin
          // Always two beats; a misplaced last flag only marks the result as erroneous.
          if (snoop_port_i.cd_valid) begin
            if (!r_beat) begin
              r_data[BeatW-1:0] <= snoop_port_i.cd.data;
              r_beat            <= 1'b1;
              if (snoop_port_i.cd.last) r_resp.error <= 1'b1;
            end else begin
              r_data[LineW-1:BeatW] <= snoop_port_i.cd.data;
              r_beat                <= 1'b0;
              if (!snoop_port_i.cd.last) r_resp.error <= 1'b1;
              r_cd_ready  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_ac_valid  <= 1'b0;
          r_cr_ready  <= 1'b0;
          r_cd_ready  <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNOOP_INIT_TIMEOUT_EN
  localparam int unsigned WdogW = 16;

  logic [WdogW-1:0] r_wdog;
  logic             r_timeout;

  // r_wdog holds (busy cycle index - 1), so setting at TimeoutCycles-2 raises the flag in busy cycle TimeoutCycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == IDLE || (r_state == RESP && rsp_ready_i)) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_wdog != '1) r_wdog <= r_wdog + WdogW'(1);
      if (r_wdog == WdogW'(TimeoutCycles - 2)) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign req_ready_o           = r_req_ready;
  assign snoop_port_o.ac_valid = r_ac_valid;
  assign snoop_port_o.ac.addr  = r_addr;
  assign snoop_port_o.ac.snoop = r_snoop;
  assign snoop_port_o.cr_ready = r_cr_ready;
  assign snoop_port_o.cd_ready = r_cd_ready;
  assign rsp_valid_o           = r_rsp_valid;
  assign rsp_resp_o            = r_resp;
  assign rsp_data_o            = r_data;
  assign busy_o                = r_busy;

endmodule

// File: doc/snoop_initiator.md
SNOOP_INITIATOR -- requirements
Module: snoop_initiator

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024, meaning cycles busy before timeout_o sets (16-bit range, >=2).
REQ-002 SHALL have port clk_i, input, 1, clock; single clock domain.
REQ-003 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid_i, input, 1, snoop request from requester valid.
REQ-005 SHALL have port req_ready_o, output, 1, request accepted.
REQ-006 SHALL have port req_addr_i, input, 64, snoop address.
REQ-007 SHALL have port req_snoop_i, input, snoop_pkg::acsnoop_t, snoop type.
REQ-008 SHALL have port snoop_port_o, output, ariane_ace::snoop_req_t, AC channel (ac_valid, ac) plus cr_ready, cd_ready toward the snooped cache.
REQ-009 SHALL have port snoop_port_i, input, ariane_ace::snoop_resp_t, ac_ready, cr_valid, cr_resp, cd_valid, cd from the snooped cache.
REQ-010 SHALL have port rsp_valid_o, input-side ready rsp_ready_i (input, 1); together a valid/ready result handshake.
REQ-011 SHALL have port rsp_resp_o, output, snoop_pkg::crresp_t, collected CR response (error possibly forced).
REQ-012 SHALL have port rsp_data_o, output, 128, collected cache line; '0 when no data transferred.
REQ-013 SHALL have port busy_o, output, 1, high whenever state != IDLE.
REQ-014 SHALL have port timeout_o, output, 1, sticky watchdog status.

Function
REQ-015 SHALL implement FSM states IDLE, SEND_AC, WAIT_CR, WAIT_CD, RESP.
REQ-016 IDLE: req_ready_o=1; on req_valid_i capture address with bits [3:0] cleared and snoop type.
REQ-017 Captured type CLEAN_INVALID, READ_SHARED, READ_ONCE or READ_UNIQUE SHALL go to SEND_AC; any other type SHALL go to RESP with rsp_resp_o.error=1, all other fields 0, no AC issued.
REQ-018 SEND_AC: ac_valid=1 with registered addr/snoop, held stable until ac_ready; same-cycle handshake SHALL move to WAIT_CR (first AC beat earliest one cycle after request acceptance).
REQ-019 WAIT_CR: cr_ready=1; on cr_valid capture cr_resp; dataTransfer=1 -> WAIT_CD, else -> RESP. cr_ready and cd_ready SHALL be 0 in all other states.
REQ-020 WAIT_CD: cd_ready=1; beat 0 -> rsp_data_o[63:0], beat 1 -> [127:64]; after beat 1 -> RESP.
REQ-021 cd.last=1 on beat 0 or last=0 on beat 1 SHALL set rsp_resp_o.error=1; exactly two beats SHALL always be consumed.
REQ-022 RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; handshake -> IDLE; new request not accepted in same cycle.
REQ-023 CR/CD valid arriving outside its wait state SHALL be ignored (not acknowledged).
REQ-024 Data and response registers SHALL clear to '0 on each accepted request.

Reset
REQ-025 On rst_i: state IDLE; ac_valid, cr_ready, cd_ready, rsp_valid_o, busy_o, timeout_o = 0; rsp_resp_o, rsp_data_o, beat counter, watchdog = '0.
REQ-026 Reset mid-transaction SHALL abandon it immediately; req_ready_o=1 first cycle after rst_i deasserts.

Configuration
REQ-027 Macro SNOOP_INIT_TIMEOUT_EN defined: 16-bit counter increments each busy cycle, clears in IDLE; reaching TimeoutCycles sets timeout_o until return to IDLE; FSM SHALL NOT abort.
REQ-028 Macro undefined: no counter; timeout_o tied 0.

Verification
REQ-029 READ_ONCE addr 0x8000_0018, ac_ready immediate, cr_resp dataTransfer=1 isShared=1, beats 0x1111/0x2222 (last on beat 1) -> ac.addr 0x8000_0010, rsp_data_o {0x2222,0x1111}, error=0.
REQ-030 CLEAN_INVALID, cr_resp all 0 -> no cd_ready, rsp_valid_o after CR, rsp_data_o 0.
REQ-031 Unsupported snoop type -> ac_valid never asserts, rsp_valid_o with error=1 next cycle.
REQ-032 cd.last=1 on beat 0 -> second beat still consumed, error=1.
REQ-033 ac_ready held low 5 cycles, rsp_ready_i low 3 cycles -> AC and result held stable throughout; busy_o high until result handshake.
REQ-034 SNOOP_INIT_TIMEOUT_EN, TimeoutCycles=8, cr_valid withheld 20 cycles -> timeout_o rises at busy cycle 8, transaction completes normally, timeout_o clears in IDLE.
